la_wb_initiator: RTL and testbench

// - Wishbone classic initiator driven from logic-analyzer probes; initiator-side counterpart to user_proj_example's WB slave port.
// - Mgmt SoC firmware posts a command (adr/dat/we/sel) on LA outputs; block runs one single-beat WB cycle on an internal user-area bus.
// - Returns read data plus an error flag on LA inputs. Lets on-chip slaves (e.g. analog pad control) be exercised without the mgmt WB path.

---
 rtl/la_wb_initiator.sv | 107 ++++++++++
 tb/tb_la_wb_initiator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_wb_initiator.sv
// la_wb_initiator: single-beat Wishbone classic initiator fed by logic-analyzer command/response probes.
// Optional bus timeout with error response enabled by defining LA_WB_TIMEOUT_EN.
module la_wb_initiator #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [DW/8-1:0] cmd_sel_i,
    input  logic [AW-1:0]   cmd_adr_i,
    input  logic [DW-1:0]   cmd_dat_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_dat_o,
    output logic            rsp_err_o,
    output logic            busy_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    input  logic            m_ack_i,
    input  logic [DW-1:0]   m_dat_i
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t state, state_n;
    logic tmo, accept, keep, cyc_n, we_n, rsp_valid_n;
    logic [DW/8-1:0] sel_n;
    logic [AW-1:0] adr_n;
    logic [DW-1:0] dat_n, rsp_dat_n;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            m_cyc_o     <= 1'b0;
            m_stb_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_sel_o     <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            state       <= state_n;
            cmd_ready_o <= !keep;
            busy_o      <= keep;
            m_cyc_o     <= cyc_n;
            m_stb_o     <= cyc_n;
            m_we_o      <= we_n;
            m_sel_o     <= sel_n;
            m_adr_o     <= adr_n;
            m_dat_o     <= dat_n;
            rsp_valid_o <= rsp_valid_n;
            rsp_dat_o   <= rsp_dat_n;
        end
    end

    always_comb begin
        state_n = (state == IDLE && cmd_valid_i)          ? BUS  :
                  (state == BUS && (m_ack_i || tmo))      ? RESP :
                  (state == RESP && rsp_ready_i)          ? IDLE : state;
    end

    // m_* hold the command from acceptance until the response is consumed
    always_comb begin
        accept      = state == IDLE && cmd_valid_i;
        keep        = state_n != IDLE;
        cyc_n       = state_n == BUS;
        we_n        = accept ? cmd_we_i  : keep && m_we_o;
        sel_n       = accept ? cmd_sel_i : keep ? m_sel_o : '0;
        adr_n       = accept ? cmd_adr_i : keep ? m_adr_o : '0;
        dat_n       = accept ? cmd_dat_i : keep ? m_dat_o : '0;
        rsp_valid_n = state_n == RESP;
        rsp_dat_n   = state == BUS ? ((m_ack_i && !m_we_o) ? m_dat_i : '0) :
                      state_n == RESP ? rsp_dat_o : '0;
    end

`ifdef LA_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic err_n;
    assign tmo   = state == BUS && cnt == CW'(TIMEOUT_CYCLES);
    assign cnt_n = (state == BUS && state_n == BUS) ? cnt + 1'b1 : '0;
    // an ack in the final counted cycle still wins over the abort
    assign err_n = state == BUS ? (tmo && !m_ack_i) : (state_n == RESP && rsp_err_o);

    always_ff @(posedge wb_clk_i) begin
        cnt       <= wb_rst_n_i ? cnt_n : '0;
        rsp_err_o <= wb_rst_n_i && err_n;
    end
`else
    assign tmo       = 1'b0;
    assign rsp_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_la_wb_initiator.sv
// tb_la_wb_initiator: directed plus randomized check of la_wb_initiator against a transaction-level model.
module tb_la_wb_initiator;
    localparam int TMO = 8;
`ifdef LA_WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, cmd_valid, cmd_ready, we, rsp_valid, rsp_ready, rsp_err, busy;
    logic cyc, stb, m_we, ack;
    logic [3:0] sel, m_sel;
    logic [31:0] adr, dat, rsp_dat, m_adr, m_dat, m_rdat;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    la_wb_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(we),
        .cmd_sel_i(sel), .cmd_adr_i(adr), .cmd_dat_i(dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(ack), .m_dat_i(m_rdat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding command, then one pending response.
    bit mh_cmd, mh_rsp, mq_we, mr_err;
    logic [3:0] mq_sel;
    logic [31:0] mq_adr, mq_dat, mr_dat;
    int waited;

    always @(posedge clk) begin
        if (!rst_n) begin
            mh_cmd <= 1'b0;
            mh_rsp <= 1'b0;
        end else if (!mh_cmd) begin
            if (cmd_valid) begin
                mh_cmd <= 1'b1;
                mq_we  <= we;
                mq_sel <= sel;
                mq_adr <= adr;
                mq_dat <= dat;
                waited <= 0;
            end
        end else if (!mh_rsp) begin
            if (ack) begin
                mh_rsp <= 1'b1;
                mr_dat <= mq_we ? 32'h0 : m_rdat;
                mr_err <= 1'b0;
            end else if (TMO_EN && waited == TMO) begin
                mh_rsp <= 1'b1;
                mr_dat <= 32'h0;
                mr_err <= 1'b1;
            end else begin
                waited <= waited + 1;
            end
        end else if (rsp_ready) begin
            mh_cmd <= 1'b0;
            mh_rsp <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cmd_ready", cmd_ready, !mh_cmd);
            check("busy", busy, mh_cmd);
            check("cyc", cyc, mh_cmd && !mh_rsp);
            check("stb", stb, mh_cmd && !mh_rsp);
            check("m_we", m_we, mh_cmd && mq_we);
            check("m_sel", m_sel, mh_cmd ? mq_sel : 4'h0);
            check("m_adr", m_adr, mh_cmd ? mq_adr : 32'h0);
            check("m_dat", m_dat, mh_cmd ? mq_dat : 32'h0);
            check("rsp_valid", rsp_valid, mh_rsp);
            if (mh_rsp) begin
                check("rsp_dat", rsp_dat, mr_dat);
                check("rsp_err", rsp_err, mr_err);
            end
        end
    end

    // Issue one command, ack in the ack_at-th cycle that cyc is high (0 = never); n = cycles cyc was high.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int ack_at, input logic [31:0] rd, input int limit, output int n);
        cmd_valid = 1'b1; we = w; adr = a; dat = d; sel = s;
        m_rdat = rd; ack = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (cyc && n < limit) begin
            n++;
            ack = (n == ack_at);
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
        rsp_ready = 1'b0; ack = 1'b0; m_rdat = 32'h0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cyc", cyc, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        run_cmd(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 3, 32'hDEAD_BEEF, 50, n);
        check("wr_cyc_cycles", n, 3);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_dat", rsp_dat, 32'h0);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_m_dat", m_dat, 32'hA5A5_5A5A);
        finish_rsp();
        check("wr_idle_ready", cmd_ready, 1);
        check("wr_idle_m_dat", m_dat, 32'h0);

        run_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3, 1, 32'h1234_5678, 50, n);
        check("rd_cyc_cycles", n, 1);
        check("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        finish_rsp();

        run_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 50, n);
        cmd_valid = 1'b1; adr = 32'h4000_0000; we = 1'b1;
        repeat (5) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_m_adr", m_adr, 32'h3000_000C);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        finish_rsp();
        @(negedge clk);
        check("bp_not_queued", busy, 0);

`ifdef LA_WB_TIMEOUT_EN
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h5555_AAAA, 100, n);
        check("tmo_cyc_cycles", n, TMO + 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_dat", rsp_dat, 32'h0);
        finish_rsp();
        run_cmd(1'b0, 32'h3000_0014, 32'h0, 4'hF, TMO + 1, 32'h0BAD_F00D, 100, n);
        check("edge_cyc_cycles", n, TMO + 1);
        check("edge_rsp_err", rsp_err, 0);
        check("edge_rsp_dat", rsp_dat, 32'h0BAD_F00D);
        finish_rsp();
`else
        run_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h5555_AAAA, 100, n);
        check("hang_cyc_cycles", n, 100);
        check("hang_cyc", cyc, 1);
        check("hang_rsp_valid", rsp_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("hang_rst_cyc", cyc, 0);
`endif

        ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy", busy, 0);
            check("stray_rsp_valid", rsp_valid, 0);
        end
        ack = 1'b0;

        cmd_valid = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'hF; m_rdat = 32'h7777_8888;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_cyc_before", cyc, 1);
        rst_n = 1'b0; ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; ack = 1'b0;
        check("mid_rst_cyc", cyc, 0);
        check("mid_rst_stb", stb, 0);
        check("mid_rst_ready", cmd_ready, 1);
        repeat (4) begin
            check("mid_rst_rsp_valid", rsp_valid, 0);
            @(negedge clk);
        end

        repeat (3000) begin
            @(negedge clk);
            rst_n     = $urandom_range(0, 199) != 0;
            cmd_valid = 1'($urandom_range(0, 1));
            we        = 1'($urandom_range(0, 1));
            sel       = 4'($urandom);
            adr       = $urandom;
            dat       = $urandom;
            m_rdat    = $urandom;
            ack       = $urandom_range(0, 9) < 3;
            rsp_ready = $urandom_range(0, 9) < 6;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
